// File: rtl/fast_score_arbiter.sv
// Round-robin front end for one shared fast_score unit: issues lane operands, tracks lane
// tags through the unit's in-order pipeline, buffers tagged scores. Optional counters: FAST_SCORE_ARB_STATS_EN.
module fast_score_arbiter #(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 8,
    parameter int  RES_DEPTH  = 4,
    localparam int LANE_W     = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_is_corner,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_center,
    input  logic [NUM_REQ*16*DATA_WIDTH-1:0] req_circle,
    input  logic [NUM_REQ*16-1:0]            req_bright_mask,
    input  logic [NUM_REQ*16-1:0]            req_dark_mask,
    output logic                             sc_in_valid,
    output logic                             sc_is_corner,
    output logic [DATA_WIDTH-1:0]            sc_center,
    output logic [16*DATA_WIDTH-1:0]         sc_circle,
    output logic [15:0]                      sc_bright_mask,
    output logic [15:0]                      sc_dark_mask,
    input  logic                             sc_output_valid,
    input  logic [DATA_WIDTH-1:0]            sc_score,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [LANE_W-1:0]                res_lane,
    output logic [DATA_WIDTH-1:0]            res_score,
    output logic                             err_orphan
`ifdef FAST_SCORE_ARB_STATS_EN
    ,
    output logic [31:0]                      stat_issued,
    output logic [31:0]                      stat_credit_stall
`endif
);
    localparam int DW    = DATA_WIDTH;
    localparam int CW    = 16 * DW;
    localparam int PTR_W = $clog2(RES_DEPTH);
    localparam int CNT_W = $clog2(RES_DEPTH + 1);

    logic [LANE_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  infl_q, infl_d;
    logic [PTR_W-1:0]  tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [LANE_W-1:0] tag_mem_q [RES_DEPTH];
    logic [LANE_W-1:0] tag_mem_d [RES_DEPTH];
    logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
    logic [PTR_W-1:0]  res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic [LANE_W-1:0] res_lane_mem_q [RES_DEPTH];
    logic [LANE_W-1:0] res_lane_mem_d [RES_DEPTH];
    logic [DW-1:0]     res_score_mem_q [RES_DEPTH];
    logic [DW-1:0]     res_score_mem_d [RES_DEPTH];
    logic              sc_in_valid_q, sc_in_valid_d, sc_is_corner_q, sc_is_corner_d;
    logic [DW-1:0]     sc_center_q, sc_center_d;
    logic [CW-1:0]     sc_circle_q, sc_circle_d;
    logic [15:0]       sc_bright_q, sc_bright_d, sc_dark_q, sc_dark_d;
    logic              err_q, err_d;

    logic              credit_ok, gnt_found, issue, ret_ok, res_pop;
    logic [LANE_W-1:0] gnt_idx, scan_idx;

    // Credits cover both the unit pipeline and the result FIFO, so a return always has room.
    assign credit_ok = ({1'b0, infl_q} + {1'b0, res_cnt_q}) < (CNT_W+1)'(RES_DEPTH);

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = LANE_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    assign issue     = credit_ok & gnt_found;
    assign req_ready = (issue && rst_n) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
    assign ret_ok    = sc_output_valid & (infl_q != '0);
    assign res_valid = (res_cnt_q != '0);
    assign res_pop   = res_valid & res_ready;

    always_comb begin
        rr_ptr_d        = rr_ptr_q;
        tag_wr_d        = tag_wr_q;
        tag_rd_d        = tag_rd_q;
        tag_mem_d       = tag_mem_q;
        res_wr_d        = res_wr_q;
        res_rd_d        = res_rd_q;
        res_lane_mem_d  = res_lane_mem_q;
        res_score_mem_d = res_score_mem_q;
        sc_in_valid_d   = issue;
        sc_is_corner_d  = sc_is_corner_q;
        sc_center_d     = sc_center_q;
        sc_circle_d     = sc_circle_q;
        sc_bright_d     = sc_bright_q;
        sc_dark_d       = sc_dark_q;
        err_d           = err_q | (sc_output_valid & (infl_q == '0));
        if (issue) begin
            tag_mem_d[tag_wr_q] = gnt_idx;
            tag_wr_d            = tag_wr_q + 1'b1;
            rr_ptr_d            = (gnt_idx == LANE_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            sc_is_corner_d      = req_is_corner[gnt_idx];
            sc_center_d         = req_center[gnt_idx*DW +: DW];
            sc_circle_d         = req_circle[gnt_idx*CW +: CW];
            sc_bright_d         = req_bright_mask[gnt_idx*16 +: 16];
            sc_dark_d           = req_dark_mask[gnt_idx*16 +: 16];
        end
        if (ret_ok) begin
            tag_rd_d                  = tag_rd_q + 1'b1;
            res_lane_mem_d[res_wr_q]  = tag_mem_q[tag_rd_q];
            res_score_mem_d[res_wr_q] = sc_score;
            res_wr_d                  = res_wr_q + 1'b1;
        end
        if (res_pop) res_rd_d = res_rd_q + 1'b1;
        case ({issue, ret_ok})
            2'b10:   infl_d = infl_q + 1'b1;
            2'b01:   infl_d = infl_q - 1'b1;
            default: infl_d = infl_q;
        endcase
        case ({ret_ok, res_pop})
            2'b10:   res_cnt_d = res_cnt_q + 1'b1;
            2'b01:   res_cnt_d = res_cnt_q - 1'b1;
            default: res_cnt_d = res_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q        <= '0;
            infl_q          <= '0;
            tag_wr_q        <= '0;
            tag_rd_q        <= '0;
            tag_mem_q       <= '{default: '0};
            res_cnt_q       <= '0;
            res_wr_q        <= '0;
            res_rd_q        <= '0;
            res_lane_mem_q  <= '{default: '0};
            res_score_mem_q <= '{default: '0};
            sc_in_valid_q   <= 1'b0;
            sc_is_corner_q  <= 1'b0;
            sc_center_q     <= '0;
            sc_circle_q     <= '0;
            sc_bright_q     <= '0;
            sc_dark_q       <= '0;
            err_q           <= 1'b0;
        end else begin
            rr_ptr_q        <= rr_ptr_d;
            infl_q          <= infl_d;
            tag_wr_q        <= tag_wr_d;
            tag_rd_q        <= tag_rd_d;
            tag_mem_q       <= tag_mem_d;
            res_cnt_q       <= res_cnt_d;
            res_wr_q        <= res_wr_d;
            res_rd_q        <= res_rd_d;
            res_lane_mem_q  <= res_lane_mem_d;
            res_score_mem_q <= res_score_mem_d;
            sc_in_valid_q   <= sc_in_valid_d;
            sc_is_corner_q  <= sc_is_corner_d;
            sc_center_q     <= sc_center_d;
            sc_circle_q     <= sc_circle_d;
            sc_bright_q     <= sc_bright_d;
            sc_dark_q       <= sc_dark_d;
            err_q           <= err_d;
        end
    end

    assign sc_in_valid    = sc_in_valid_q;
    assign sc_is_corner   = sc_is_corner_q;
    assign sc_center      = sc_center_q;
    assign sc_circle      = sc_circle_q;
    assign sc_bright_mask = sc_bright_q;
    assign sc_dark_mask   = sc_dark_q;
    assign err_orphan     = err_q;
    // Head is masked when empty so stale entries never leak onto the result bus.
    assign res_lane       = res_valid ? res_lane_mem_q[res_rd_q] : '0;
    assign res_score      = res_valid ? res_score_mem_q[res_rd_q] : '0;

`ifdef FAST_SCORE_ARB_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d, stat_stall_q, stat_stall_d;

    always_comb begin
        stat_issued_d = stat_issued_q;
        stat_stall_d  = stat_stall_q;
        if (issue && stat_issued_q != '1) stat_issued_d = stat_issued_q + 32'd1;
        if ((|req_valid) && !credit_ok && stat_stall_q != '1) stat_stall_d = stat_stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_issued       = stat_issued_q;
    assign stat_credit_stall = stat_stall_q;
`endif
endmodule
